reg_control_8b: RTL and testbench

- 8-bit multi-function register (shift register / loadable register) driven by a 3-bit opcode.
- Every rising clock edge performs one of eight operations on its internal register: clear, parallel load, logical shift, arithmetic shift, serial-in shift, or rotate.
- Sits in the datapath as a general-purpose shift/rotate unit; the register contents drive `reg_out` directly.

---
 rtl/reg_control_8b_if.sv | 21 ++
 rtl/reg_control_8b.sv | 61 ++++++
 tb/tb_reg_control_8b.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_control_8b_if.sv
// Operation/data bundle for the multi-function shift register.
// Latency: none (wires only); the register itself adds one cycle.
// Backpressure: none; the register accepts one operation every clock.
//
// Signals:
//   control  3-bit opcode, sampled on the rising clock edge
//   s_in     serial bit that enters the MSB on the serial-in shift
//   d_in     parallel load data
//   reg_out  current register contents
interface reg_control_8b_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       control;
  logic             s_in;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] reg_out;

  // master drives operations and observes the register; slave is the register
  modport master (output control, s_in, d_in, input reg_out);
  modport slave  (input control, s_in, d_in, output reg_out);
endinterface

// File: rtl/reg_control_8b.sv
// General-purpose register: clear, load, shift (logical/arithmetic/serial-in), rotate.
// Latency: 1 cycle; the result of the operation sampled at an edge is on reg_out after it.
// Backpressure: none; exactly one operation is applied on every clock edge.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces the register to zero immediately
//   bus    slave side of reg_control_8b_if (control, s_in, d_in in; reg_out out)
module reg_control_8b #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  reg_control_8b_if.slave bus
);

  typedef enum logic [2:0] {
    OP_CLEAR = 3'b000,
    OP_LOAD  = 3'b001,
    OP_LSR   = 3'b010,
    OP_LSL   = 3'b011,
    OP_ASR   = 3'b100,
    OP_SSR   = 3'b101,
    OP_ROR   = 3'b110,
    OP_ROL   = 3'b111
  } op_t;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  op_t              op;

  assign op = op_t'(bus.control);

  // Full decode over all eight codes: bits shifted out are simply dropped.
  always_comb begin
    q_next = q;
    unique case (op)
      OP_CLEAR: q_next = '0;
      OP_LOAD:  q_next = bus.d_in;
      OP_LSR:   q_next = {1'b0, q[WIDTH-1:1]};
      OP_LSL:   q_next = {q[WIDTH-2:0], 1'b0};
      OP_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_SSR:   q_next = {bus.s_in, q[WIDTH-1:1]};
      OP_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      OP_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      default:  q_next = q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Output comes straight from the flops; no combinational path from inputs.
  assign bus.reg_out = q;

endmodule

// File: tb/tb_reg_control_8b.sv
// Directed self-checking bench for reg_control_8b.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_reg_control_8b;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reg_control_8b_if #(.WIDTH(8)) bus ();

  reg_control_8b #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one operation, let one rising edge apply it, return 1 unit after the edge.
  task automatic apply(input logic [2:0] c, input logic s, input logic [7:0] d);
    bus.control = c;
    bus.s_in    = s;
    bus.d_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    // Reset is high from time zero
    #1;
    checks++;
    if (bus.reg_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: reg_out=%h expected %h", bus.reg_out, 8'h00);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    apply(3'b001, 1'b0, 8'h5A);
    checks++;
    if (bus.reg_out !== 8'h5A) begin
      errors++;
      $display("FAIL reset_first_load: reg_out=%h expected %h", bus.reg_out, 8'h5A);
    end
    // Assert reset mid-cycle, away from any edge, with a load pending
    bus.control = 3'b001;
    bus.d_in    = 8'hFF;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.reg_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: reg_out=%h expected %h", bus.reg_out, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.reg_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold_%0d: reg_out=%h expected %h", i, bus.reg_out, 8'h00);
      end
    end
    #2;
    reset = 1'b0;
    // The pending load executes on the first edge after release
    @(posedge clk);
    #1;
    checks++;
    if (bus.reg_out !== 8'hFF) begin
      errors++;
      $display("FAIL reset_release_load: reg_out=%h expected %h", bus.reg_out, 8'hFF);
    end
  endtask

  task automatic test_load_shift;
    logic [2:0] ops [4] = '{3'b010, 3'b011, 3'b100, 3'b100};
    logic [7:0] exp [4] = '{8'h55, 8'hAA, 8'hD5, 8'hEA};
    apply(3'b001, 1'b0, 8'hAA);
    checks++;
    if (bus.reg_out !== 8'hAA) begin
      errors++;
      $display("FAIL load_aa: reg_out=%h expected %h", bus.reg_out, 8'hAA);
    end
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], 1'b1, 8'h00);
      checks++;
      if (bus.reg_out !== exp[i]) begin
        errors++;
        $display("FAIL shift_step_%0d: reg_out=%h expected %h", i, bus.reg_out, exp[i]);
      end
    end
  endtask

  task automatic test_serial_in;
    logic       sin [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp [4] = '{8'h80, 8'hC0, 8'h60, 8'hB0};
    apply(3'b000, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      apply(3'b101, sin[i], 8'hFF);
      checks++;
      if (bus.reg_out !== exp[i]) begin
        errors++;
        $display("FAIL serial_step_%0d: reg_out=%h expected %h", i, bus.reg_out, exp[i]);
      end
    end
  endtask

  task automatic test_rotate;
    logic [2:0] ops [3] = '{3'b110, 3'b111, 3'b111};
    logic [7:0] exp [3] = '{8'hC0, 8'h81, 8'h03};
    apply(3'b001, 1'b0, 8'h81);
    for (int i = 0; i < 3; i++) begin
      apply(ops[i], 1'b0, 8'h00);
      checks++;
      if (bus.reg_out !== exp[i]) begin
        errors++;
        $display("FAIL rotate_step_%0d: reg_out=%h expected %h", i, bus.reg_out, exp[i]);
      end
    end
    apply(3'b001, 1'b0, 8'h3C);
    for (int i = 0; i < 8; i++) apply(3'b110, 1'b0, 8'h00);
    checks++;
    if (bus.reg_out !== 8'h3C) begin
      errors++;
      $display("FAIL rotate_right_x8: reg_out=%h expected %h", bus.reg_out, 8'h3C);
    end
    apply(3'b001, 1'b0, 8'hB1);
    apply(3'b111, 1'b0, 8'h00);
    checks++;
    if (bus.reg_out !== 8'h63) begin
      errors++;
      $display("FAIL rotate_left_b1: reg_out=%h expected %h", bus.reg_out, 8'h63);
    end
    for (int i = 0; i < 7; i++) apply(3'b111, 1'b0, 8'h00);
    checks++;
    if (bus.reg_out !== 8'hB1) begin
      errors++;
      $display("FAIL rotate_left_x8: reg_out=%h expected %h", bus.reg_out, 8'hB1);
    end
  endtask

  task automatic test_clear_hold;
    apply(3'b001, 1'b0, 8'hFF);
    apply(3'b000, 1'b1, 8'hFF);
    checks++;
    if (bus.reg_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_ff: reg_out=%h expected %h", bus.reg_out, 8'h00);
    end
    apply(3'b001, 1'b0, 8'h81);
    // Between edges: opcode and data wiggle, register must not move
    bus.control = 3'b011;
    bus.d_in    = 8'h00;
    #2;
    checks++;
    if (bus.reg_out !== 8'h81) begin
      errors++;
      $display("FAIL hold_mid_a: reg_out=%h expected %h", bus.reg_out, 8'h81);
    end
    bus.d_in = 8'h5A;
    bus.s_in = 1'b1;
    #2;
    checks++;
    if (bus.reg_out !== 8'h81) begin
      errors++;
      $display("FAIL hold_mid_b: reg_out=%h expected %h", bus.reg_out, 8'h81);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.reg_out !== 8'h02) begin
      errors++;
      $display("FAIL hold_then_lsl: reg_out=%h expected %h", bus.reg_out, 8'h02);
    end
  endtask

  task automatic test_boundaries;
    logic [7:0] ld  [7] = '{8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [2:0] ops [7] = '{3'b100, 3'b100, 3'b011, 3'b010, 3'b100, 3'b110, 3'b111};
    logic [7:0] exp [7] = '{8'h3F, 8'hC0, 8'h00, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 7; i++) begin
      apply(3'b001, 1'b0, ld[i]);
      apply(ops[i], 1'b0, 8'h00);
      checks++;
      if (bus.reg_out !== exp[i]) begin
        errors++;
        $display("FAIL boundary_%0d: reg_out=%h expected %h", i, bus.reg_out, exp[i]);
      end
    end
    // Zero stays zero under every shift/rotate
    apply(3'b000, 1'b0, 8'hFF);
    for (int op = 2; op < 8; op++) begin
      apply(3'(op), 1'b0, 8'hFF);
      checks++;
      if (bus.reg_out !== 8'h00) begin
        errors++;
        $display("FAIL zero_op_%0d: reg_out=%h expected %h", op, bus.reg_out, 8'h00);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.control = 3'b000;
    bus.s_in    = 1'b0;
    bus.d_in    = 8'h00;
    test_reset();
    test_load_shift();
    test_serial_in();
    test_rotate();
    test_clear_hold();
    test_boundaries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
